// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path.
// Contents:
//   state_t            frame sequencing states (IDLE, START, DATA, PARITY, STOP)
//   MUX_* constants    line-source select codes for the output bit multiplexer
//   PARITY_* constants parity type encoding of the parity_type input
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Output multiplexer sources
  localparam logic [1:0] MUX_START  = 2'd0;  // constant 0 (start bit)
  localparam logic [1:0] MUX_STOP   = 2'd1;  // constant 1 (idle / stop bit)
  localparam logic [1:0] MUX_DATA   = 2'd2;  // serializer register output
  localparam logic [1:0] MUX_PARITY = 2'd3;  // registered parity bit

  // parity_type encoding
  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_parity_calculator.sv
// Registered parity of the frame word, captured on the accept edge so it
// stays constant for the whole frame regardless of later input changes.
// Ports:
//   clk          baud-rate clock
//   reset        synchronous active-high reset, clears parity_bit
//   load         accept strobe from the frame controller
//   data         word being accepted
//   parity_type  0 = even, 1 = odd
//   parity_bit   registered parity of the last loaded word
module parity_calculator
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  parity_type,
  output logic                  parity_bit
);

  logic xor_all;

  assign xor_all = ^data;

  always_ff @(posedge clk) begin
    if (reset) begin
      parity_bit <= 1'b0;
    end else if (load) begin
      // Even parity makes the total count of ones even, so the bit equals
      // the XOR reduction; odd parity is its complement.
      case (parity_type)
        PARITY_EVEN: parity_bit <= xor_all;
        PARITY_ODD:  parity_bit <= ~xor_all;
        default:     parity_bit <= xor_all;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_controller.sv
// Frame-sequencing controller for the UART transmitter. One clk cycle is one
// bit period. Latches a word on accept, then walks START -> DATA x DATA_WIDTH
// -> [PARITY] -> STOP, driving the serializer enable/index and the line mux.
// Ports:
//   clk               baud-rate clock
//   reset             synchronous active-high reset (highest priority)
//   data_in           word to transmit, sampled on accept
//   data_valid        send request; honoured only in IDLE or STOP
//   parity_enable     append a parity bit, sampled on accept
//   parity_type       0 = even, 1 = odd, sampled on accept
//   parallel_data     latched frame word for the serializer
//   serial_enable     serializer load enable (combinational decode)
//   serial_data_index bit index the serializer loads (combinational decode)
//   mux_select        line source select (combinational decode)
//   parity_bit        registered parity of the latched word
//   busy              high from the cycle after accept through the last stop
module uart_tx_controller
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          data_valid,
  input  logic                          parity_enable,
  input  logic                          parity_type,
  output logic [DATA_WIDTH-1:0]         parallel_data,
  output logic                          serial_enable,
  output logic [$clog2(DATA_WIDTH)-1:0] serial_data_index,
  output logic [1:0]                    mux_select,
  output logic                          parity_bit,
  output logic                          busy
);

  localparam int IDX_W = $clog2(DATA_WIDTH);
  // The counter never goes past the last data bit, so IDX_W bits suffice.
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_WIDTH - 1);

  state_t           state;
  logic [IDX_W-1:0] bit_cnt;
  logic             parity_en_lat;
  logic             accept;

  // A new word is taken from IDLE, or from STOP so frames can run
  // back-to-back without an idle bit in between.
  assign accept = data_valid && ((state == IDLE) || (state == STOP));

  parity_calculator #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .clk         (clk),
    .reset       (reset),
    .load        (accept),
    .data        (data_in),
    .parity_type (parity_type),
    .parity_bit  (parity_bit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      parallel_data <= '0;
      parity_en_lat <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            parallel_data <= data_in;
            parity_en_lat <= parity_enable;
            busy          <= 1'b1;
            state         <= START;
          end
        end

        START: begin
          bit_cnt <= '0;
          state   <= DATA;
        end

        DATA: begin
          if (bit_cnt == LAST_BIT) begin
            bit_cnt <= '0;
            state   <= parity_en_lat ? PARITY : STOP;
          end else begin
            bit_cnt <= bit_cnt + IDX_W'(1);
          end
        end

        PARITY: begin
          state <= STOP;
        end

        STOP: begin
          if (accept) begin
            parallel_data <= data_in;
            parity_en_lat <= parity_enable;
            busy          <= 1'b1;
            state         <= START;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          bit_cnt <= '0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // The serializer registers its input, so each cycle requests the bit that
  // must be on the line in the following cycle: START pre-loads bit 0 and
  // DATA cycle i loads bit i+1. The last data cycle has nothing left to load.
  always_comb begin
    mux_select        = MUX_STOP;
    serial_enable     = 1'b0;
    serial_data_index = '0;
    case (state)
      START: begin
        mux_select        = MUX_START;
        serial_enable     = 1'b1;
        serial_data_index = '0;
      end
      DATA: begin
        mux_select = MUX_DATA;
        if (bit_cnt != LAST_BIT) begin
          serial_enable     = 1'b1;
          serial_data_index = bit_cnt + IDX_W'(1);
        end
      end
      PARITY: begin
        mux_select = MUX_PARITY;
      end
      default: begin
        mux_select = MUX_STOP;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_controller.sv
module tb_uart_tx_controller;

  localparam int W  = 8;
  localparam int IW = $clog2(W);

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  data_in;
  logic          data_valid;
  logic          parity_enable;
  logic          parity_type;
  logic [W-1:0]  parallel_data;
  logic          serial_enable;
  logic [IW-1:0] serial_data_index;
  logic [1:0]    mux_select;
  logic          parity_bit;
  logic          busy;

  uart_tx_controller #(.DATA_WIDTH(W)) dut (
    .clk               (clk),
    .reset             (reset),
    .data_in           (data_in),
    .data_valid        (data_valid),
    .parity_enable     (parity_enable),
    .parity_type       (parity_type),
    .parallel_data     (parallel_data),
    .serial_enable     (serial_enable),
    .serial_data_index (serial_data_index),
    .mux_select        (mux_select),
    .parity_bit        (parity_bit),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  // Serializer and output mux attached to the controller
  logic ser_q;
  logic line;
  always @(posedge clk) if (serial_enable) ser_q <= parallel_data[serial_data_index];
  always_comb begin
    line = 1'b1;
    case (mux_select)
      2'd0: line = 1'b0;
      2'd1: line = 1'b1;
      2'd2: line = ser_q;
      2'd3: line = parity_bit;
      default: line = 1'b1;
    endcase
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: each accepted word expands into a list of per-cycle
  // expectations for the frame; the head of the list is the current cycle.
  typedef struct {
    logic [1:0]    mux;
    logic          en;
    logic [IW-1:0] idx;
    logic          ln;
  } exp_t;

  exp_t       mq[$];
  logic [W-1:0] m_pd = '0;
  logic         m_pb = 1'b0;
  bit           chk_en = 1'b0;

  always @(posedge clk) begin : model
    bit   acc;
    exp_t e;
    logic pb;
    acc = !reset && data_valid && (mq.size() <= 1);
    if (mq.size() != 0) void'(mq.pop_front());
    if (reset) begin
      mq.delete();
      m_pd <= '0;
      m_pb <= 1'b0;
    end else if (acc) begin
      pb = (^data_in) ^ parity_type;
      m_pd <= data_in;
      m_pb <= pb;
      e.mux = 2'd0; e.en = 1'b1; e.idx = '0; e.ln = 1'b0;
      mq.push_back(e);
      for (int i = 0; i < W; i++) begin
        e.mux = 2'd2;
        e.en  = (i < W - 1);
        e.idx = (i < W - 1) ? IW'(i + 1) : '0;
        e.ln  = data_in[i];
        mq.push_back(e);
      end
      if (parity_enable) begin
        e.mux = 2'd3; e.en = 1'b0; e.idx = '0; e.ln = pb;
        mq.push_back(e);
      end
      e.mux = 2'd1; e.en = 1'b0; e.idx = '0; e.ln = 1'b1;
      mq.push_back(e);
    end
  end

  always @(negedge clk) begin : compare
    exp_t e;
    logic eb;
    if (chk_en) begin
      if (mq.size() != 0) begin
        e = mq[0]; eb = 1'b1;
      end else begin
        e.mux = 2'd1; e.en = 1'b0; e.idx = '0; e.ln = 1'b1; eb = 1'b0;
      end
      check("mux_select", 32'(mux_select), 32'(e.mux));
      check("serial_enable", 32'(serial_enable), 32'(e.en));
      check("serial_data_index", 32'(serial_data_index), 32'(e.idx));
      check("busy", 32'(busy), 32'(eb));
      check("parallel_data", 32'(parallel_data), 32'(m_pd));
      check("parity_bit", 32'(parity_bit), 32'(m_pb));
      check("line", 32'(line), 32'(e.ln));
    end
  end

  // Called at a negedge in IDLE: one-cycle request, returns at the START negedge
  task automatic send(input logic [W-1:0] w, input logic pe, input logic pt);
    data_in = w; parity_enable = pe; parity_type = pt; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic capture(output logic [31:0] cap, output int n);
    cap = '0; n = 0;
    for (int k = 0; k < 40; k++) begin
      if (!busy) break;
      cap = {cap[30:0], line};
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [31:0] cap;
    int          n;
    bit          found;

    reset = 1'b1; data_valid = 1'b0; data_in = '0;
    parity_enable = 1'b0; parity_type = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mux", 32'(mux_select), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pdata", 32'(parallel_data), 32'd0);
    check("rst_en", 32'(serial_enable), 32'd0);
    reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // Even parity, 8'hA5
    send(8'hA5, 1'b1, 1'b0);
    check("a5_start_mux", 32'(mux_select), 32'd0);
    capture(cap, n);
    check("a5_line", cap, 32'b01010010101);
    check("a5_len", 32'(n), 32'd11);
    repeat (2) @(negedge clk);

    // No parity, 8'h3C
    send(8'h3C, 1'b0, 1'b0);
    capture(cap, n);
    check("3c_line", cap, 32'b0001111001);
    check("3c_len", 32'(n), 32'd10);
    repeat (2) @(negedge clk);

    // Back-to-back, odd parity
    data_in = 8'h01; parity_enable = 1'b1; parity_type = 1'b1; data_valid = 1'b1;
    @(negedge clk);
    data_in = 8'h80;
    check("b2b_par1", 32'(parity_bit), 32'd0);
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (mux_select == 2'd1 && busy) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check("b2b_stop_found", 32'(found), 32'd1);
    @(negedge clk);
    data_valid = 1'b0;
    check("b2b_start2_mux", 32'(mux_select), 32'd0);
    check("b2b_start2_busy", 32'(busy), 32'd1);
    check("b2b_pdata2", 32'(parallel_data), 32'h80);
    check("b2b_par2", 32'(parity_bit), 32'd0);
    wait_idle();
    repeat (2) @(negedge clk);

    // Ignored request during DATA
    send(8'h00, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    data_in = 8'hFF; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    wait_idle();
    check("ign_pdata", 32'(parallel_data), 32'd0);
    repeat (3) @(negedge clk);
    check("ign_no_frame", 32'(busy), 32'd0);

    // Mid-frame reset during DATA bit 4
    send(8'h55, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    check("mr_in_data", 32'(mux_select), 32'd2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mr_mux", 32'(mux_select), 32'd1);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_pdata", 32'(parallel_data), 32'd0);
    check("mr_en", 32'(serial_enable), 32'd0);
    send(8'h0F, 1'b0, 1'b0);
    capture(cap, n);
    check("0f_line", cap, 32'b0111100001);
    check("0f_len", 32'(n), 32'd10);

    // Request together with reset is dropped
    data_in = 8'h5A; data_valid = 1'b1; reset = 1'b1;
    @(negedge clk);
    data_valid = 1'b0; reset = 1'b0;
    check("rst_vs_valid_busy", 32'(busy), 32'd0);
    @(negedge clk);

    // Randomized traffic, including config changes mid-frame and resets
    for (int c = 0; c < 1500; c++) begin
      data_in       = W'($urandom);
      data_valid    = ($urandom_range(0, 2) == 0);
      parity_enable = 1'($urandom);
      parity_type   = 1'($urandom);
      reset         = ($urandom_range(0, 79) == 0);
      @(negedge clk);
    end
    data_valid = 1'b0; reset = 1'b0;
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
